// File: rtl/usart_tx_fifo.sv
// usart_tx_fifo -- UART transmitter with an internal transmit FIFO.
//
// A producer pushes words with a one-cycle `write` strobe. Each queued word
// is sent as one frame: start bit, DATA_BITS data bits LSB first, an optional
// parity bit, then STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT cycles.
// Queued frames go out back-to-back: when a word is waiting, the last stop
// cycle is followed directly by the next start bit.
//
// Ports:
//   clk     in   block clock, all logic on posedge
//   nreset  in   asynchronous active-low reset
//   txdata  in   word to transmit, sampled when `write` is high
//   write   in   push strobe
//   full    out  FIFO holds FIFO_DEPTH words (registered)
//   level   out  FIFO occupancy, not counting the word in the shifter
//   ovf     out  one-cycle pulse after a write was dropped because of `full`
//   idle    out  FIFO empty and serialiser in IDLE
//   tx      out  serial line (registered, idles high)
//
// Handshake: there is no back-pressure. A write is accepted iff `write` is
// high and the registered `full` is low at the sampling edge; otherwise the
// word is dropped and `ovf` pulses in the following cycle.
module usart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [DATA_BITS-1:0] txdata,
    input  logic                 write,
    output logic                 full,
    output logic [LVL_W-1:0]     level,
    output logic                 ovf,
    output logic                 idle,
    output logic                 tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam int BI_W  = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BI_W-1:0]  DATA_LAST = BI_W'(DATA_BITS - 1);
    localparam logic [BI_W-1:0]  STOP_LAST = BI_W'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        LVL_W < $clog2(FIFO_DEPTH + 1)) begin : g_bad_param
        $error("usart_tx_fifo: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     count_q, count_d;
    logic                 full_q, full_d;
    logic                 ovf_q, ovf_d;

    // Serialiser
    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BI_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 idle_q, idle_d;

    logic                 push;
    logic                 pop;
    logic                 fifo_nempty;
    logic [DATA_BITS-1:0] pop_word;
    logic                 pop_par;

    assign push        = write && !full_q;
    assign fifo_nempty = (count_q != '0);
    assign pop_word    = mem_q[rd_ptr_q];
    // Odd parity makes the total number of ones odd, even parity even.
    assign pop_par     = (PARITY == 1) ? ~(^pop_word) : (^pop_word);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        if (state_q == S_IDLE) begin
            div_d = '0;
            tx_d  = 1'b1;
            if (fifo_nempty) begin
                pop     = 1'b1;
                shreg_d = pop_word;
                par_d   = pop_par;
                state_d = S_START;
                tx_d    = 1'b0;
            end
        end else if (div_q != DIV_LAST) begin
            div_d = div_q + DIV_W'(1);
        end else begin
            // Bit boundary: tx_d is the value of the next bit.
            div_d = '0;
            case (state_q)
                S_START: begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end
                S_DATA: begin
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BI_W'(1);
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end
                end
                S_PAR: begin
                    state_d   = S_STOP;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end
                S_STOP: begin
                    if (bit_idx_q == STOP_LAST) begin
                        bit_idx_d = '0;
                        // A waiting word starts immediately, no IDLE cycle.
                        if (fifo_nempty) begin
                            pop     = 1'b1;
                            shreg_d = pop_word;
                            par_d   = pop_par;
                            state_d = S_START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BI_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == LVL_FULL);
        ovf_d  = write && full_q;
        idle_d = (count_d == '0) && (state_d == S_IDLE);
    end

    // Storage is not reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= txdata;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            idle_q    <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            idle_q    <= idle_d;
        end
    end

    assign full  = full_q;
    assign level = count_q;
    assign ovf   = ovf_q;
    assign idle  = idle_q;
    assign tx    = tx_q;

endmodule

// File: tb/tb_usart_tx_fifo.sv
// tb_usart_tx_fifo -- directed bench for usart_tx_fifo.
//
// Four instances share clock and reset:
//   0: defaults (8N1, 4 clk/bit)   1: even parity   2: odd parity
//   3: 7 data bits, odd parity, 2 stop bits, 8 clk/bit
// Expected line bits are pushed into exp_q when a word is written; a line
// monitor on the selected instance pops one entry per bit time and compares
// every cycle of that bit.
module tb_usart_tx_fifo;

    logic       clk;
    logic       nreset;
    logic [8:0] wdata;
    logic       wr      [4];
    logic       tx_w    [4];
    logic       idle_w  [4];
    logic       full_w  [4];
    logic       ovf_w   [4];
    logic [2:0] level_w [4];

    int errors = 0;
    int checks = 0;

    logic exp_q[$];
    int   sel = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    usart_tx_fifo u_dut0 (
        .clk(clk), .nreset(nreset), .txdata(wdata[7:0]), .write(wr[0]),
        .full(full_w[0]), .level(level_w[0]), .ovf(ovf_w[0]),
        .idle(idle_w[0]), .tx(tx_w[0])
    );

    usart_tx_fifo #(.PARITY(2)) u_dut1 (
        .clk(clk), .nreset(nreset), .txdata(wdata[7:0]), .write(wr[1]),
        .full(full_w[1]), .level(level_w[1]), .ovf(ovf_w[1]),
        .idle(idle_w[1]), .tx(tx_w[1])
    );

    usart_tx_fifo #(.PARITY(1)) u_dut2 (
        .clk(clk), .nreset(nreset), .txdata(wdata[7:0]), .write(wr[2]),
        .full(full_w[2]), .level(level_w[2]), .ovf(ovf_w[2]),
        .idle(idle_w[2]), .tx(tx_w[2])
    );

    usart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2), .PARITY(1), .CLKS_PER_BIT(8)) u_dut3 (
        .clk(clk), .nreset(nreset), .txdata(wdata[6:0]), .write(wr[3]),
        .full(full_w[3]), .level(level_w[3]), .ovf(ovf_w[3]),
        .idle(idle_w[3]), .tx(tx_w[3])
    );

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bits.
    task automatic push_frame(input logic [8:0] v, input int dbits, input int par, input int stops);
        logic ones;
        ones = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < dbits; i++) begin
            exp_q.push_back(v[i]);
            ones = ones ^ v[i];
        end
        if (par == 1) exp_q.push_back(~ones);
        if (par == 2) exp_q.push_back(ones);
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    endtask

    // Called just after a falling clock edge; returns one cycle later.
    task automatic drive_write(input int d, input logic [8:0] v);
        wdata = v;
        wr[d] = 1'b1;
        @(negedge clk);
        wr[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int limit, output int n);
        n = 0;
        while (idle_w[d] !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- line monitor ----------------
    logic mon_busy = 1'b0;
    logic mon_cur  = 1'b1;
    logic mon_ok   = 1'b1;
    int   mon_phase = 0;

    always @(negedge clk) begin
        int cpb;
        cpb = (sel == 3) ? 8 : 4;
        if (!nreset) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx_w[sel] === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_start observed=0 expected=1 dut=%0d", sel);
                end else begin
                    mon_cur   = exp_q.pop_front();
                    mon_ok    = (tx_w[sel] === mon_cur);
                    mon_phase = 1;
                    mon_busy  = 1'b1;
                end
            end
        end else begin
            if (tx_w[sel] !== mon_cur) mon_ok = 1'b0;
            mon_phase++;
        end
        if (mon_busy && mon_phase == cpb) begin
            checks++;
            assert (mon_ok) else begin
                errors++;
                $error("FAIL line_bit observed=mismatch expected=%0b dut=%0d", mon_cur, sel);
            end
            if (exp_q.size() != 0) begin
                mon_cur   = exp_q.pop_front();
                mon_ok    = 1'b1;
                mon_phase = 0;
            end else begin
                mon_busy = 1'b0;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        logic [8:0] burst [6];
        burst = '{9'h0A1, 9'h0B2, 9'h0C3, 9'h0D4, 9'h0E5, 9'h0F6};

        nreset = 1'b0;
        wdata  = '0;
        for (int i = 0; i < 4; i++) wr[i] = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("reset_tx", tx_w[0], 1);
        chk("reset_idle", idle_w[0], 1);
        chk("reset_full", full_w[0], 0);
        chk("reset_level", level_w[0], 0);
        chk("reset_ovf", ovf_w[0], 0);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Single 8N1 frame of 0x55
        sel = 0;
        push_frame(9'h055, 8, 0, 1);
        drive_write(0, 9'h055);
        chk("single_level_after_push", level_w[0], 1);
        chk("single_idle_fall", idle_w[0], 0);
        chk("single_tx_still_high", tx_w[0], 1);
        @(negedge clk);
        chk("single_start_bit", tx_w[0], 0);
        chk("single_level_after_pop", level_w[0], 0);
        wait_idle(0, 200, n);
        chk("single_frame_cycles", n, 40);
        chk("single_queue_drained", exp_q.size(), 0);
        chk("single_tx_idle", tx_w[0], 1);
        @(negedge clk);

        // Even parity, 0x07 -> parity bit 1, 44-cycle frame
        sel = 1;
        push_frame(9'h007, 8, 2, 1);
        drive_write(1, 9'h007);
        wait_idle(1, 200, n);
        chk("even_par_idle_cycles", n, 45);
        chk("even_par_drained", exp_q.size(), 0);
        @(negedge clk);

        // Odd parity, 0x07 -> parity bit 0
        sel = 2;
        push_frame(9'h007, 8, 1, 1);
        drive_write(2, 9'h007);
        wait_idle(2, 200, n);
        chk("odd_par_idle_cycles", n, 45);
        chk("odd_par_drained", exp_q.size(), 0);
        @(negedge clk);

        // 7O2 at 8 clk/bit, 0x41 -> 88-cycle frame
        sel = 3;
        push_frame(9'h041, 7, 1, 2);
        drive_write(3, 9'h041);
        wait_idle(3, 300, n);
        chk("7o2_idle_cycles", n, 89);
        chk("7o2_drained", exp_q.size(), 0);
        chk("7o2_tx_idle", tx_w[3], 1);
        @(negedge clk);

        // Burst of 6 writes: first popped, 4 fill the FIFO, 6th dropped
        sel = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                chk("burst_full", full_w[0], 1);
                chk("burst_level4", level_w[0], 4);
            end
            wdata = burst[i];
            wr[0] = 1'b1;
            if (i < 5) push_frame(burst[i], 8, 0, 1);
            @(negedge clk);
        end
        wr[0] = 1'b0;
        chk("burst_ovf_pulse", ovf_w[0], 1);
        chk("burst_level_kept", level_w[0], 4);
        @(negedge clk);
        chk("burst_ovf_one_cycle", ovf_w[0], 0);

        // Write while full on the edge that pops for back-to-back START
        repeat (34) @(negedge clk);
        drive_write(0, 9'h099);
        chk("popwrite_ovf", ovf_w[0], 1);
        chk("popwrite_level3", level_w[0], 3);
        chk("popwrite_not_full", full_w[0], 0);
        wait_idle(0, 400, n);
        chk("burst_total_cycles", n, 160);
        chk("burst_drained", exp_q.size(), 0);
        @(negedge clk);

        // Asynchronous reset in the middle of data bit 3
        push_frame(9'h0A5, 8, 0, 1);
        push_frame(9'h05A, 8, 0, 1);
        wdata = 9'h0A5;
        wr[0] = 1'b1;
        @(negedge clk);
        wdata = 9'h05A;
        @(negedge clk);
        wr[0] = 1'b0;
        chk("prereset_level", level_w[0], 1);
        repeat (17) @(negedge clk);
        nreset = 1'b0;
        #1;
        chk("async_reset_tx", tx_w[0], 1);
        chk("async_reset_idle", idle_w[0], 1);
        chk("async_reset_level", level_w[0], 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        chk("after_reset_tx", tx_w[0], 1);
        chk("after_reset_idle", idle_w[0], 1);

        push_frame(9'h03C, 8, 0, 1);
        drive_write(0, 9'h03C);
        wait_idle(0, 200, n);
        chk("after_reset_frame_cycles", n, 41);
        chk("after_reset_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usart_tx_fifo.md
# usart_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO, configurable frame format and back-to-back framing. It succeeds the fixed 8N1 transmitter and sits between the capture/readout logic of the logic analyzer and the PC-facing serial line. It runs on a single clock with no rdclk domain. A producer pushes words with a one-cycle strobe. The block serialises them LSB-first with no idle gap between queued frames.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5..9.
- CLKS_PER_BIT, 4: clk cycles per UART bit, legal ≥2.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries, power of two ≥2.
- LVL_W, $clog2(FIFO_DEPTH+1): width of `level`.

- clk  in  1  block clock; one clock, all logic on posedge.
- nreset  in  1  reset, asynchronous, active-low.
- txdata  in  DATA_BITS  word to transmit, sampled with `write`.
- write  in  1  push strobe, one word per cycle where high.
- full  out  1  FIFO holds FIFO_DEPTH words; reset 0.
- level  out  LVL_W  FIFO occupancy, excluding the word in the shifter; reset 0.
- ovf  out  1  one-cycle pulse when a write is dropped; reset 0.
- idle  out  1  high when the FIFO is empty and the FSM is in IDLE; reset 1.
- tx  out  1  serial line; reset 1.

## Operation
- FIFO
  - A write is accepted iff `write`=1 and `full`=0 at the sampling edge.
  - `full` is registered. A write in the same cycle as a pop while full is rejected and pulses `ovf`.
  - Pointers wrap modulo FIFO_DEPTH.
  - `level` updates on the edge after a push or pop. Simultaneous push and pop leaves `level` unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - Every state except IDLE lasts exactly CLKS_PER_BIT cycles per bit, counted by a bit-tick counter `div`.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register, compute parity, go to START.
  - START: tx=0, then go to DATA.
  - DATA: tx = shreg[bit_idx], with bit_idx running 0..DATA_BITS-1 (LSB first). After the last bit, go to PAR if PARITY≠0, else STOP.
  - PAR: tx = parity bit. Odd means the data bits plus the parity bit contain an odd number of 1s. Even means they contain an even number of 1s.
  - STOP: tx=1 for STOP_BITS bit times.
    - On the final cycle, if the FIFO is non-empty, pop and go directly to START (no IDLE cycle).
    - Otherwise go to IDLE.
- Frame length in cycles: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT.
- The parity bit is computed at pop time from the popped word, never from live `txdata`.
- Reset (asynchronous, any time including mid-frame):
  - tx=1, FSM=IDLE, FIFO emptied, counters cleared.
  - idle=1, full=0, level=0, ovf=0.
  - The interrupted frame is abandoned, never resumed.
- Illegal parameter values are flagged by a generate-time `$error`.

## Timing
- Latency with FIFO empty and FSM IDLE:
  - Edge N samples `write`; the word is in the FIFO after edge N.
  - Edge N+1 pops it; tx=0 from edge N+1.
  - `idle` falls after edge N.
- `level` briefly reads 1 after edge N, then 0 after edge N+1.
- Back-to-back frames:
  - The stop bit's last cycle is followed immediately by the start bit.
  - The spacing between consecutive start-bit falling edges is exactly the frame length.
- `idle` rises on the edge after STOP ends with the FIFO empty.
- `ovf` is high for exactly the cycle after the rejected write edge.
- A write accepted during a frame never alters that frame.
- tx is a registered output, glitch-free.

## Test plan
- Defaults, write 0x55 once:
  - tx low from the edge after write for 4 cycles.
  - Then 1,0,1,0,1,0,1,0, each for 4 cycles, then high for 4 cycles.
  - idle=1 at cycle 42.
- PARITY=2, write 0x07: parity bit = 1, frame is 44 cycles. With PARITY=1 the same word gives parity bit 0.
- DATA_BITS=7, STOP_BITS=2, PARITY=1, CLKS_PER_BIT=8, write 0x41: 11-bit frame of 88 cycles, tx high for the final 16.
- Defaults, 6 writes on consecutive cycles:
  - The first is popped at once.
  - The next 4 fill the FIFO (full=1, level=4).
  - The 6th is dropped with a one-cycle `ovf` pulse.
  - 5 frames go out back-to-back, start bits 40 cycles apart, 200 cycles total.
- Write while full in the same cycle as a STOP→START pop: write rejected, ovf pulses, level goes 4→3.
- Assert nreset low mid-DATA bit 3:
  - tx=1, idle=1, level=0 immediately, without waiting for a clk edge.
  - After release, a new write produces a clean full frame.
